// File: rtl/ysyx_22050598_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ysyx_22050598_muldiv_unit
// Iterative RV64M multiply/divide unit for the EX stage. Multiply is radix-2
// shift-add on operand magnitudes; divide is radix-2 restoring. W ops run on
// 32-bit operands and return a sign-extended 64-bit result.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid           EX holds a muldiv op with operands ready
//   is_mul/div/rem     op select (priority mul > div > rem)
//   mul_hi             00 low, 01 MULH, 10 MULHSU, 11 MULHU
//   is_signed          DIV/REM vs DIVU/REMU
//   is_word            W variant
//   src1, src2         rs1 / rs2 values
//   flush              abort any op, return to IDLE
//   out_ready          EX retires the result this cycle
//   ready              idle, can accept
//   out_valid          result valid (held until out_ready)
//   result             final result
// ---------------------------------------------------------------------------
module ysyx_22050598_muldiv_unit #(
   parameter int XLEN = 64,
   parameter int WLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic            is_mul,
   input  logic            is_div,
   input  logic            is_rem,
   input  logic [1:0]      mul_hi,
   input  logic            is_signed,
   input  logic            is_word,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   input  logic            out_ready,
   output logic            ready,
   output logic            out_valid,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
      return {{(XLEN-WLEN){v[WLEN-1]}}, v[WLEN-1:0]};
   endfunction

   function automatic logic [XLEN-1:0] zext_w(input logic [XLEN-1:0] v);
      return {{(XLEN-WLEN){1'b0}}, v[WLEN-1:0]};
   endfunction

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                opmul_q, opmul_d;
   logic                oprem_q, oprem_d;
   logic                hi_q, hi_d;
   logic                word_q, word_d;
   logic                neg_q, neg_d;
   // mul: 2N-bit accumulator; div: remainder in the low half
   logic [2*XLEN-1:0]   acc_q, acc_d;
   // mul: shifted multiplicand; div: divisor in the low half
   logic [2*XLEN-1:0]   mcand_q, mcand_d;
   // mul: multiplier shifted right; div: dividend shifted out / quotient in
   logic [XLEN-1:0]     mplier_q, mplier_d;
   logic [XLEN-1:0]     result_q, result_d;

   // accept-side decode
   logic            oprem_s, a_signed_s, b_signed_s, a_neg_s, b_neg_s;
   logic            div_zero_s, ovf_s, special_s;
   logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, min_s, spec_res_s;
   // iteration / fixup
   logic [XLEN:0]   rem_sh_s;
   logic [XLEN-1:0] sub_s, quo_s, remv_s, raw_s, fix_res_s;
   logic [2*XLEN-1:0] prod_s;

   // Operand extension, magnitude conversion and divide special-case detection.
   always_comb begin
      oprem_s    = ~is_mul & ~is_div & is_rem;
      a_signed_s = is_mul ? ((mul_hi == 2'b01) || (mul_hi == 2'b10)) : is_signed;
      b_signed_s = is_mul ? (mul_hi == 2'b01) : is_signed;
      a_ext_s    = is_word ? (a_signed_s ? sext_w(src1) : zext_w(src1)) : src1;
      b_ext_s    = is_word ? (b_signed_s ? sext_w(src2) : zext_w(src2)) : src2;
      a_neg_s    = a_signed_s & a_ext_s[XLEN-1];
      b_neg_s    = b_signed_s & b_ext_s[XLEN-1];
      a_mag_s    = a_neg_s ? -a_ext_s : a_ext_s;
      b_mag_s    = b_neg_s ? -b_ext_s : b_ext_s;
      // most-negative value of the op width, as it appears after sign extension
      min_s      = is_word ? {{(XLEN-WLEN){1'b1}}, 1'b1, {(WLEN-1){1'b0}}}
                           : {1'b1, {(XLEN-1){1'b0}}};
      div_zero_s = (b_ext_s == {XLEN{1'b0}});
      ovf_s      = is_signed & (a_ext_s == min_s) & (b_ext_s == {XLEN{1'b1}});
      special_s  = ~is_mul & (div_zero_s | ovf_s);
      if (div_zero_s) begin
         spec_res_s = oprem_s ? (is_word ? sext_w(src1) : src1) : {XLEN{1'b1}};
      end else begin
         spec_res_s = oprem_s ? {XLEN{1'b0}} : a_ext_s;
      end
   end

   // Restoring-divide trial subtraction and final sign/width fixup.
   always_comb begin
      rem_sh_s  = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
      sub_s     = rem_sh_s[XLEN-1:0] - mcand_q[XLEN-1:0];
      prod_s    = neg_q ? -acc_q : acc_q;
      quo_s     = neg_q ? -mplier_q : mplier_q;
      remv_s    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      if (opmul_q) begin
         raw_s = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
      end else begin
         raw_s = oprem_q ? remv_s : quo_s;
      end
      fix_res_s = word_q ? sext_w(raw_s) : raw_s;
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opmul_d  = opmul_q;
      oprem_d  = oprem_q;
      hi_d     = hi_q;
      word_d   = word_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      result_d = result_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid && (is_mul || is_div || is_rem)) begin
                  opmul_d = is_mul;
                  oprem_d = oprem_s;
                  hi_d    = (mul_hi != 2'b00);
                  word_d  = is_word;
                  neg_d   = oprem_s ? a_neg_s : (a_neg_s ^ b_neg_s);
                  cnt_d   = is_word ? CW'(WLEN) : CW'(XLEN);
                  acc_d   = {(2*XLEN){1'b0}};
                  if (is_mul) begin
                     mcand_d  = {{XLEN{1'b0}}, a_mag_s};
                     mplier_d = b_mag_s;
                  end else begin
                     mcand_d  = {{XLEN{1'b0}}, b_mag_s};
                     // W dividends are pre-aligned so the next bit is always the MSB
                     mplier_d = is_word ? (a_mag_s << WLEN) : a_mag_s;
                  end
                  if (special_s) begin
                     result_d = spec_res_s;
                     state_d  = S_DONE;
                  end else begin
                     state_d  = S_BUSY;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_BUSY: begin
               if (cnt_q != {CW{1'b0}}) begin
                  cnt_d = cnt_q - CW'(1);
                  if (opmul_q) begin
                     if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                     end else begin
                        acc_d = acc_q;
                     end
                     mcand_d  = mcand_q << 1;
                     mplier_d = mplier_q >> 1;
                  end else begin
                     if (rem_sh_s >= {1'b0, mcand_q[XLEN-1:0]}) begin
                        acc_d[XLEN-1:0] = sub_s;
                        mplier_d        = {mplier_q[XLEN-2:0], 1'b1};
                     end else begin
                        acc_d[XLEN-1:0] = rem_sh_s[XLEN-1:0];
                        mplier_d        = {mplier_q[XLEN-2:0], 1'b0};
                     end
                  end
               end else begin
                  // all iterations done: register the sign/width-fixed result
                  result_d = fix_res_s;
                  state_d  = S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CW{1'b0}};
         opmul_q  <= 1'b0;
         oprem_q  <= 1'b0;
         hi_q     <= 1'b0;
         word_q   <= 1'b0;
         neg_q    <= 1'b0;
         acc_q    <= {(2*XLEN){1'b0}};
         mcand_q  <= {(2*XLEN){1'b0}};
         mplier_q <= {XLEN{1'b0}};
         result_q <= {XLEN{1'b0}};
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opmul_q  <= opmul_d;
         oprem_q  <= oprem_d;
         hi_q     <= hi_d;
         word_q   <= word_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         result_q <= result_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22050598_muldiv_unit.sv
module tb_ysyx_22050598_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        is_mul = 1'b0;
   logic        is_div = 1'b0;
   logic        is_rem = 1'b0;
   logic [1:0]  mul_hi = 2'b00;
   logic        is_signed = 1'b0;
   logic        is_word = 1'b0;
   logic [63:0] src1 = 64'd0;
   logic [63:0] src2 = 64'd0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic        ready;
   logic        out_valid;
   logic [63:0] result;

   int total = 0;
   int bad = 0;

   ysyx_22050598_muldiv_unit #(.XLEN(64), .WLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .is_mul(is_mul),
      .is_div(is_div), .is_rem(is_rem), .mul_hi(mul_hi), .is_signed(is_signed),
      .is_word(is_word), .src1(src1), .src2(src2), .flush(flush),
      .out_ready(out_ready), .ready(ready), .out_valid(out_valid), .result(result)
   );

   always #5 clk = ~clk;

   // Issue one op from a negedge, scramble the inputs after accept, and wait
   // (bounded) for out_valid. lat = cycles after the accept edge, -1 on timeout.
   task automatic start_op(input logic m, input logic d, input logic r,
                           input logic [1:0] hi, input logic sg, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
      is_mul = m; is_div = d; is_rem = r; mul_hi = hi;
      is_signed = sg; is_word = w; src1 = a; src2 = b;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      src1 = 64'h5A5A_1234_DEAD_BEEF; src2 = 64'h0F0F_0000_FFFF_0001;
      is_mul = ~m; mul_hi = ~hi; is_word = ~w;
   endtask

   task automatic wait_valid(output int lat, output logic [63:0] res);
      lat = -1;
      if (out_valid) lat = 0;
      for (int k = 1; k <= 200 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) lat = k;
      end
      res = result;
   endtask

   task automatic retire;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      total++;
      if (ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
         bad++;
         $display("FAIL reset: ready=%b out_valid=%b result=%h, want 1 0 0", ready, out_valid, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul;
      int lat; logic [63:0] res;
      start_op(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
      wait_valid(lat, res);
      total++;
      if (lat !== 65) begin bad++; $display("FAIL mul_latency: got %0d want 65", lat); end
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mul_7x-3: got %h want ffffffffffffffeb", res); end
      retire();
   endtask

   task automatic test_mulh;
      int lat; logic [63:0] res;
      start_op(1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(lat, res);
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulhu: got %h want fffffffffffffffe", res); end
      retire();
      start_op(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd0) begin bad++; $display("FAIL mulh: got %h want 0", res); end
      retire();
      // MULHSU(-1, 2) = high half of -2 = all ones
      start_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      wait_valid(lat, res);
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL mulhsu: got %h want ffffffffffffffff", res); end
      retire();
   endtask

   task automatic test_divw;
      int lat; logic [63:0] res;
      start_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      wait_valid(lat, res);
      total++;
      if (lat !== 33) begin bad++; $display("FAIL divw_latency: got %0d want 33", lat); end
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL divw: got %h want fffffffffffffffd", res); end
      retire();
      start_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
      wait_valid(lat, res);
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL remw: got %h want ffffffffffffffff", res); end
      retire();
      // 64-bit DIVU 100/7 = 14, REMU = 2
      start_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'd100, 64'd7);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd14) begin bad++; $display("FAIL divu64: got %h want e", res); end
      retire();
      start_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 64'd100, 64'd7);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd2) begin bad++; $display("FAIL remu64: got %h want 2", res); end
      retire();
   endtask

   task automatic test_special;
      int lat; logic [63:0] res;
      start_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'd12345, 64'd0);
      wait_valid(lat, res);
      total++;
      if (lat < 0 || lat > 1) begin bad++; $display("FAIL divu0_latency: got %0d want <=1", lat); end
      total++;
      if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL divu0: got %h want ffffffffffffffff", res); end
      retire();
      start_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 64'h8000_0000_0000_0123, 64'd0);
      wait_valid(lat, res);
      total++;
      if (res !== 64'h8000_0000_0000_0123) begin bad++; $display("FAIL rem0: got %h want 8000000000000123", res); end
      retire();
      start_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(lat, res);
      total++;
      if (lat < 0 || lat > 1 || res !== 64'h8000_0000_0000_0000) begin
         bad++; $display("FAIL div_ovf: got %h lat %0d want 8000000000000000 lat<=1", res, lat);
      end
      retire();
      start_op(1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd0) begin bad++; $display("FAIL rem_ovf: got %h want 0", res); end
      retire();
   endtask

   task automatic test_flush;
      int lat; logic [63:0] res; logic seen;
      start_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 64'd1000, 64'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL flush_idle: ready=%b out_valid=%b want 1 0", ready, out_valid);
      end
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_result: out_valid rose, want never"); end
      // flush together with an accept: nothing starts
      is_mul = 1'b1; is_div = 1'b0; is_rem = 1'b0; mul_hi = 2'b00; is_word = 1'b0;
      src1 = 64'd3; src2 = 64'd5; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      total++;
      if (ready !== 1'b1) begin bad++; $display("FAIL flush_vs_accept: ready=%b want 1", ready); end
      start_op(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'd3, 64'd5);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd15 || lat !== 65) begin bad++; $display("FAIL mul_after_flush: got %h lat %0d want f lat 65", res, lat); end
      retire();
   endtask

   task automatic test_hold_back_to_back;
      int lat; logic [63:0] res; logic stable;
      start_op(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 64'd6, 64'd7);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd42 || lat !== 33) begin bad++; $display("FAIL mulw: got %h lat %0d want 2a lat 33", res, lat); end
      stable = 1'b1;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid !== 1'b1 || result !== 64'd42 || ready !== 1'b0) stable = 1'b0;
      end
      total++;
      if (stable !== 1'b1) begin bad++; $display("FAIL done_hold: out_valid=%b result=%h want 1 2a", out_valid, result); end
      // retire and offer a new op in the same cycle: it must not be taken
      out_ready = 1'b1; in_valid = 1'b1; is_mul = 1'b1; is_word = 1'b0; src1 = 64'd9; src2 = 64'd9;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b0 || ready !== 1'b1) begin
         bad++; $display("FAIL retire: out_valid=%b ready=%b want 0 1", out_valid, ready);
      end
      start_op(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'd9, 64'd9);
      wait_valid(lat, res);
      total++;
      if (res !== 64'd81) begin bad++; $display("FAIL back_to_back: got %h want 51", res); end
      retire();
   endtask

   task automatic test_reset_mid_busy;
      start_op(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'd77, 64'd5);
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
         bad++; $display("FAIL reset_mid_busy: ready=%b out_valid=%b result=%h want 1 0 0", ready, out_valid, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_divw();
      test_special();
      test_flush();
      test_hold_back_to_back();
      test_reset_mid_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
